// File: rtl/bt_cmd_decoder_pkg.sv
// Shared character codes, command letters and FSM state encoding for the
// Bluetooth command-frame decoder.
package bt_cmd_decoder_pkg;

    localparam logic [7:0] CH_START = 8'h24;
    localparam logic [7:0] CH_END   = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_NINE  = 8'h39;

    localparam logic [7:0] CMD_U = 8'h55;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_S = 8'h53;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_CMD = 2'd1,
        ST_GET_ARG = 2'd2,
        ST_GET_END = 2'd3
    } state_t;

    function automatic logic is_bit_arg(input logic [7:0] a);
        return (a == CH_ZERO) || (a == CH_ONE);
    endfunction

endpackage

// File: rtl/bt_cmd_decoder_timeout.sv
// Saturating up-count timeout: clears on restart or while idle, flags once
// the count reaches N-1 and holds there until restarted.
module bt_cmd_decoder_timeout #(
    parameter int N = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);
    localparam int            W  = $clog2(N);
    localparam logic [W-1:0]  TC = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || !run) begin
            r_cnt <= '0;
        end else if (r_cnt != TC) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = run && (r_cnt == TC);

endmodule

// File: rtl/bt_cmd_decoder.sv
// Parses "$",CMD,ARG,"\n" frames from the UART receiver into held direction
// buttons, a fire pulse and a speed setting. States: IDLE, GET_CMD, GET_ARG, GET_END.
module bt_cmd_decoder
    import bt_cmd_decoder_pkg::*;
#(
    parameter int         BYTE_TMO = 1_040_000,
    parameter int         HOLD_TMO = 50_000_000,
    parameter logic [3:0] SPD_RST  = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] dir,
    output logic       fire,
    output logic [3:0] speed,
    output logic       frame_ok,
    output logic       frame_err
);
    state_t     r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_arg;

    logic       w_good;
    logic [3:0] w_dir_next;
    logic [3:0] w_spd_next;
    logic       w_fire_next;
    logic       w_accept;
    logic       w_byte_exp;
    logic       w_hold_exp;

    // '0'/'1' differ only in bit 0, and '0'..'9' carry their value in the low nibble.
    always_comb begin
        w_good      = 1'b0;
        w_dir_next  = dir;
        w_spd_next  = speed;
        w_fire_next = 1'b0;
        case (r_cmd)
            CMD_U: if (is_bit_arg(r_arg)) begin w_good = 1'b1; w_dir_next[3] = r_arg[0]; end
            CMD_D: if (is_bit_arg(r_arg)) begin w_good = 1'b1; w_dir_next[2] = r_arg[0]; end
            CMD_L: if (is_bit_arg(r_arg)) begin w_good = 1'b1; w_dir_next[1] = r_arg[0]; end
            CMD_R: if (is_bit_arg(r_arg)) begin w_good = 1'b1; w_dir_next[0] = r_arg[0]; end
            CMD_F: begin
                w_good      = 1'b1;
                w_fire_next = 1'b1;
            end
            CMD_S: if ((r_arg >= CH_ZERO) && (r_arg <= CH_NINE)) begin
                w_good     = 1'b1;
                w_spd_next = r_arg[3:0];
            end
            default: ;
        endcase
    end

    assign w_accept = rx_valid && (r_state == ST_GET_END) && (rx_data == CH_END) && w_good;

    bt_cmd_decoder_timeout #(.N(BYTE_TMO)) u_byte_tmo (
        .clk     (clk),
        .reset   (reset),
        .run     (r_state != ST_IDLE),
        .restart (rx_valid),
        .expired (w_byte_exp)
    );

    bt_cmd_decoder_timeout #(.N(HOLD_TMO)) u_hold_tmo (
        .clk     (clk),
        .reset   (reset),
        .run     (1'b1),
        .restart (w_accept),
        .expired (w_hold_exp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_arg     <= '0;
            dir       <= '0;
            fire      <= 1'b0;
            speed     <= SPD_RST;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            fire      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            // Link-loss release; an accepted frame later in this block overrides it.
            if (w_hold_exp) begin
                dir <= '0;
            end
            if (rx_valid) begin
                if ((rx_data == CH_START) && (r_state != ST_IDLE)) begin
                    frame_err <= 1'b1;
                    r_state   <= ST_GET_CMD;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (rx_data == CH_START) begin
                                r_state <= ST_GET_CMD;
                            end
                        end
                        ST_GET_CMD: begin
                            r_cmd   <= rx_data;
                            r_state <= ST_GET_ARG;
                        end
                        ST_GET_ARG: begin
                            r_arg   <= rx_data;
                            r_state <= ST_GET_END;
                        end
                        ST_GET_END: begin
                            r_state <= ST_IDLE;
                            if (w_accept) begin
                                dir      <= w_dir_next;
                                speed    <= w_spd_next;
                                fire     <= w_fire_next;
                                frame_ok <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end else if (w_byte_exp) begin
                frame_err <= 1'b1;
                r_state   <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Directed bench for bt_cmd_decoder: a frame table with expected outputs plus
// hand-written sequences for timeouts, resync and reset mid-frame.
module tb_bt_cmd_decoder;
    localparam logic [3:0] SPD_RST = 4'd3;
    localparam logic [7:0] NL = 8'h0A;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] dir;
    logic       fire;
    logic [3:0] speed;
    logic       frame_ok;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bt_cmd_decoder #(.BYTE_TMO(50), .HOLD_TMO(200), .SPD_RST(SPD_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .dir       (dir),
        .fire      (fire),
        .speed     (speed),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    typedef struct {
        string      name;
        logic [31:0] frm;
        logic [3:0] dir;
        logic [3:0] spd;
        logic       fire;
        logic       ok;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [31:0] f, input logic [3:0] d,
                       input logic [3:0] s, input logic fi, input logic ok, input logic er);
        vec_t v;
        v.name = n; v.frm = f; v.dir = d; v.spd = s; v.fire = fi; v.ok = ok; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    // Sends four back-to-back bytes, then returns one negedge after the last is sampled.
    task automatic send_frame(input logic [31:0] f);
        for (int i = 0; i < 4; i++) drive(1'b1, f[31-8*i -: 8]);
        drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_pulses_clear(input string name);
        chk(name, {1'b0, fire, frame_ok, frame_err}, 4'b0000);
    endtask

    initial begin
        add("u1",    {"$U1", NL},      4'b1000, SPD_RST, 1'b0, 1'b1, 1'b0);
        add("u0",    {"$U0", NL},      4'b0000, SPD_RST, 1'b0, 1'b1, 1'b0);
        add("s7",    {"$S7", NL},      4'b0000, 4'd7,    1'b0, 1'b1, 1'b0);
        add("sx",    {"$SX", NL},      4'b0000, 4'd7,    1'b0, 1'b0, 1'b1);
        add("f0",    {"$F0", NL},      4'b0000, 4'd7,    1'b1, 1'b1, 1'b0);
        add("q1",    {"$Q1", NL},      4'b0000, 4'd7,    1'b0, 1'b0, 1'b1);
        add("l1",    {"$L1", NL},      4'b0010, 4'd7,    1'b0, 1'b1, 1'b0);
        add("l1z",   "$L1Z",           4'b0010, 4'd7,    1'b0, 1'b0, 1'b1);
        add("junk",  "AAAA",           4'b0010, 4'd7,    1'b0, 1'b0, 1'b0);
        add("u1b",   {"$U1", NL},      4'b1010, 4'd7,    1'b0, 1'b1, 1'b0);
        add("d1",    {"$D1", NL},      4'b1110, 4'd7,    1'b0, 1'b1, 1'b0);
        add("u2",    {"$U2", NL},      4'b1110, 4'd7,    1'b0, 1'b0, 1'b1);
        add("s9",    {"$S9", NL},      4'b1110, 4'd9,    1'b0, 1'b1, 1'b0);
        add("scolon",{"$S:", NL},      4'b1110, 4'd9,    1'b0, 1'b0, 1'b1);
        add("s0",    {"$S0", NL},      4'b1110, 4'd0,    1'b0, 1'b1, 1'b0);
        add("r1",    {"$R1", NL},      4'b1111, 4'd0,    1'b0, 1'b1, 1'b0);
        add("l0",    {"$L0", NL},      4'b1101, 4'd0,    1'b0, 1'b1, 1'b0);
        add("fnl",   {"$F", NL, NL},   4'b1101, 4'd0,    1'b1, 1'b1, 1'b0);

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk("rst_dir",   dir, 4'b0000);
        chk("rst_speed", speed, SPD_RST);
        chk_pulses_clear("rst_pulses");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            send_frame(vecs[i].frm);
            chk({vecs[i].name, " dir"},   dir,   vecs[i].dir);
            chk({vecs[i].name, " speed"}, speed, vecs[i].spd);
            chk({vecs[i].name, " pulses"}, {1'b0, fire, frame_ok, frame_err},
                {1'b0, vecs[i].fire, vecs[i].ok, vecs[i].err});
            drive(1'b0, 8'h00);
            chk_pulses_clear({vecs[i].name, " pulse_len"});
        end

        // Byte timeout: "$L" then silence.
        do_reset();
        drive(1'b1, "$");
        drive(1'b1, "L");
        idle(50);
        chk("btmo_early", {3'b0, frame_err}, 4'b0000);
        idle(1);
        chk("btmo_err", {1'b0, fire, frame_ok, frame_err}, 4'b0001);
        idle(1);
        chk_pulses_clear("btmo_err_len");
        send_frame({"$L1", NL});
        chk("btmo_next_dir", dir, 4'b0010);
        chk("btmo_next_ok", {3'b0, frame_ok}, 4'b0001);

        // A byte arriving in the expiry cycle keeps the frame alive.
        drive(1'b1, "$");
        drive(1'b1, "R");
        idle(49);
        drive(1'b1, "1");
        drive(1'b1, NL);
        chk("bwin_no_err", {3'b0, frame_err}, 4'b0000);
        drive(1'b0, 8'h00);
        chk("bwin_dir", dir, 4'b0011);
        chk("bwin_ok", {1'b0, fire, frame_ok, frame_err}, 4'b0010);

        // Hold timeout releases the buttons.
        do_reset();
        send_frame({"$R1", NL});
        chk("hold_set", dir, 4'b0001);
        idle(199);
        chk("hold_before", dir, 4'b0001);
        idle(1);
        chk("hold_release", dir, 4'b0000);
        chk("hold_speed", speed, SPD_RST);

        // Frame accepted exactly on the hold expiry cycle wins.
        send_frame({"$R1", NL});
        idle(195);
        drive(1'b1, "$");
        drive(1'b1, "R");
        drive(1'b1, "1");
        drive(1'b1, NL);
        drive(1'b0, 8'h00);
        chk("hold_win_dir", dir, 4'b0001);
        chk("hold_win_ok", {3'b0, frame_ok}, 4'b0001);
        idle(10);
        chk("hold_restart", dir, 4'b0001);

        // Resync on a second '$'.
        do_reset();
        send_frame({"$S5", NL});
        send_frame({"$U1", NL});
        drive(1'b1, "$");
        drive(1'b1, "D");
        drive(1'b1, "$");
        drive(1'b1, "R");
        chk("resync_err", {1'b0, fire, frame_ok, frame_err}, 4'b0001);
        drive(1'b1, "1");
        drive(1'b1, NL);
        drive(1'b0, 8'h00);
        chk("resync_dir", dir, 4'b1001);
        chk("resync_ok", {1'b0, fire, frame_ok, frame_err}, 4'b0010);
        chk("resync_speed", speed, 4'd5);

        // Reset mid-frame discards the partial frame.
        drive(1'b1, "$");
        drive(1'b1, "U");
        #2 reset = 1'b0;
        #1;
        chk("midrst_dir", dir, 4'b0000);
        chk("midrst_speed", speed, SPD_RST);
        chk_pulses_clear("midrst_pulses");
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        drive(1'b1, "1");
        drive(1'b1, NL);
        drive(1'b0, 8'h00);
        chk("midrst_tail_dir", dir, 4'b0000);
        chk_pulses_clear("midrst_tail_pulses");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
